// File: rtl/sseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package sseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK  = 8'hFF;
    localparam int   MAX_DIGITS = 16;

    // Active-low anode vector with only the addressed digit pulled low.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_low(input logic [3:0] idx);
        return ~(16'd1 << idx);
    endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Mod-N counter with a terminal-count flag; advances only while en_i is high.
module sseg_prescaler #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    assign tc_o    = (count_q == W'(N - 1));
    assign count_o = count_q;

    // NOTE: assign a default to every always_comb output before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = tc_o ? '0 : count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment driver: slot prescaler, per-slot input latch,
// dead-time, PWM dimming, blinking and registered anode/segment outputs.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 50000,
    parameter int DEAD_CYCLES  = 4,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS*8-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]      slot_cnt;
    logic                  slot_end;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  frame_tc;
    logic                  frame_wrap;
    logic                  past_dead;
    logic                  lit;
    logic [MAX_DIGITS-1:0] an_full;
    logic                  unused_bits;

    logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic                  blink_phase_q, blink_phase_d;
    seg_t                  seg_lat_q, seg_lat_d;
    logic                  blank_lat_q, blank_lat_d;
    logic                  blink_lat_q, blink_lat_d;
    logic [BRIGHT_W-1:0]   bright_lat_q, bright_lat_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  sseg_q, sseg_d;
    logic                  frame_tick_q, frame_tick_d;

    sseg_prescaler #(.N(TICK_DIV)) u_slot_presc (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (slot_cnt),
        .tc_o    (slot_end)
    );

    assign frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    sseg_prescaler #(.N(BLINK_FRAMES)) u_frame_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (frame_wrap),
        .count_o (frame_cnt),
        .tc_o    (frame_tc)
    );

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign past_dead = 1'b1;
        end else begin : g_dead
            assign past_dead = (slot_cnt >= CNT_W'(DEAD_CYCLES));
        end
    endgenerate

    // Upper anode bits beyond NUM_DIGITS and the frame index are intentionally unused.
    assign unused_bits = ^{frame_cnt, an_full};

    always_comb begin
        idx_nxt       = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        idx_d         = idx_q;
        seg_lat_d     = seg_lat_q;
        blank_lat_d   = blank_lat_q;
        blink_lat_d   = blink_lat_q;
        bright_lat_d  = bright_lat_q;
        pwm_d         = pwm_q + BRIGHT_W'(1);
        blink_phase_d = blink_phase_q ^ (frame_wrap && frame_tc);
        frame_tick_d  = frame_wrap;

        // Inputs are sampled only at the slot boundary, for the digit about to be shown.
        if (slot_end) begin
            idx_d        = idx_nxt;
            seg_lat_d    = digits[{idx_nxt, 3'b000} +: 8];
            blank_lat_d  = blank_mask[idx_nxt];
            blink_lat_d  = blink_mask[idx_nxt];
            bright_lat_d = brightness;
        end

        an_full = anode_onehot_low(4'(idx_q));
        lit     = past_dead
                  && !blank_lat_q
                  && !(blink_phase_q && blink_lat_q)
                  && ((&bright_lat_q) || (pwm_q < bright_lat_q));
        an_d    = lit ? an_full[NUM_DIGITS-1:0] : '1;
        sseg_d  = lit ? seg_lat_q : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q         <= '0;
            pwm_q         <= '0;
            blink_phase_q <= 1'b0;
            seg_lat_q     <= SEG_BLANK;
            blank_lat_q   <= 1'b1;
            blink_lat_q   <= 1'b0;
            bright_lat_q  <= '0;
            an_q          <= '1;
            sseg_q        <= SEG_BLANK;
            frame_tick_q  <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            blink_phase_q <= blink_phase_d;
            seg_lat_q     <= seg_lat_d;
            blank_lat_q   <= blank_lat_d;
            blink_lat_q   <= blink_lat_d;
            bright_lat_q  <= bright_lat_d;
            an_q          <= an_d;
            sseg_q        <= sseg_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule
